// File: rtl/layer_frame_packer.sv
// Store-and-forward packer: one frame in, [tdest][length][payload] out; output starts the cycle after input tlast.
// Input stalls (tready low) while a packet drains; output holds data/tlast steady under m_axis_tready backpressure.
module layer_frame_packer #(
   parameter int DEPTH = 64
) (
   input  logic        clk_core,
   input  logic        clk_core_rst,
   input  logic [7:0]  s_axis_tdata,
   input  logic [7:0]  s_axis_tdest,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        stat_frame_dropped,
   output logic [15:0] stat_dropped_count,
   output logic        status_busy
);
   localparam int         AW      = $clog2(DEPTH);
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   typedef enum logic [2:0] {IDLE, FILL, DROP, HDR_ID, HDR_LEN, PAYLOAD} state_t;

   state_t      state_q, state_d;
   logic        rst_done_q;
   logic [7:0]  tdest_q;
   logic [7:0]  count_q;
   logic [7:0]  rd_idx_q;
   logic [15:0] drop_cnt;
   logic        drop_pulse_q;
   logic [7:0]  buf_mem [DEPTH];

   logic        s_hs, m_hs, full, last_rd, drop_evt, buf_we;
   logic [AW-1:0] wr_idx;

   // rst_done_q keeps tready low while reset is held, even though the state reads IDLE
   assign s_axis_tready = rst_done_q && (state_q inside {IDLE, FILL, DROP});
   assign m_axis_tvalid = state_q inside {HDR_ID, HDR_LEN, PAYLOAD};
   assign s_hs          = s_axis_tvalid && s_axis_tready;
   assign m_hs          = m_axis_tvalid && m_axis_tready;
   assign full          = (count_q == DEPTH_B);
   assign last_rd       = (rd_idx_q == count_q - 8'd1);

   assign stat_frame_dropped = drop_pulse_q;
   assign stat_dropped_count = drop_cnt;
   assign status_busy        = (state_q != IDLE);

   always_ff @(posedge clk_core or posedge clk_core_rst) begin
      if (clk_core_rst) state_q <= IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      drop_evt = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_hs) state_d = s_axis_tlast ? HDR_ID : FILL;
         end
         FILL: begin
            if (s_hs) begin
               if (full) begin
                  // overflow byte is discarded; a tlast here ends the frame on the spot
                  state_d  = s_axis_tlast ? IDLE : DROP;
                  drop_evt = s_axis_tlast;
               end else if (s_axis_tlast) begin
                  state_d = HDR_ID;
               end
            end
         end
         DROP: begin
            if (s_hs && s_axis_tlast) begin
               state_d  = IDLE;
               drop_evt = 1'b1;
            end
         end
         HDR_ID: begin
            if (m_hs) state_d = HDR_LEN;
         end
         HDR_LEN: begin
            if (m_hs) state_d = PAYLOAD;
         end
         PAYLOAD: begin
            if (m_hs && last_rd) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_axis_tdata = 8'd0;
      m_axis_tlast = 1'b0;
      case (state_q)
         HDR_ID:  m_axis_tdata = tdest_q;
         HDR_LEN: m_axis_tdata = count_q;
         PAYLOAD: begin
            m_axis_tdata = buf_mem[rd_idx_q[AW-1:0]];
            m_axis_tlast = last_rd;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_core or posedge clk_core_rst) begin
      if (clk_core_rst) begin
         rst_done_q   <= 1'b0;
         tdest_q      <= 8'd0;
         count_q      <= 8'd0;
         rd_idx_q     <= 8'd0;
         drop_cnt     <= 16'd0;
         drop_pulse_q <= 1'b0;
      end else begin
         rst_done_q   <= 1'b1;
         drop_pulse_q <= drop_evt;
         if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         if (state_q == IDLE && s_hs) begin
            tdest_q <= s_axis_tdest;
            count_q <= 8'd1;
         end else if (state_q == FILL && s_hs && !full) begin
            count_q <= count_q + 8'd1;
         end
         if (state_q == PAYLOAD && m_hs) rd_idx_q <= last_rd ? 8'd0 : rd_idx_q + 8'd1;
      end
   end

   // payload storage carries no reset; count_q gates what is ever read back
   assign wr_idx = (state_q == IDLE) ? '0 : count_q[AW-1:0];
   assign buf_we = s_hs && (state_q == IDLE || (state_q == FILL && !full));

   always_ff @(posedge clk_core) begin
      if (buf_we) buf_mem[wr_idx] <= s_axis_tdata;
   end
endmodule

// File: tb/tb_layer_frame_packer.sv
// Directed + randomized bench for layer_frame_packer (DEPTH=8) with a frame-level reference model.
module tb_layer_frame_packer;
   localparam int DEPTH = 8;

   logic        clk_core = 1'b0;
   logic        clk_core_rst = 1'b1;
   logic [7:0]  s_axis_tdata = 8'd0;
   logic [7:0]  s_axis_tdest = 8'd0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        stat_frame_dropped;
   logic [15:0] stat_dropped_count;
   logic        status_busy;

   always #5 clk_core = ~clk_core;

   layer_frame_packer #(.DEPTH(DEPTH)) dut (
      .clk_core           (clk_core),
      .clk_core_rst       (clk_core_rst),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tdest       (s_axis_tdest),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tready      (s_axis_tready),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tlast       (m_axis_tlast),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .stat_frame_dropped (stat_frame_dropped),
      .stat_dropped_count (stat_dropped_count),
      .status_busy        (status_busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rdy_mode = 0;
   int lowcnt = 0, overlap = 0, pulses = 0;
   int rise_cyc = -1, hs_cyc = -1, first_hs_cyc = -1;
   int first_out_cyc = -1, last_out_cyc = -1;
   bit first_out_seen = 1'b0;
   int exp_drops = 0;
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   logic       held_vld = 1'b0;
   logic [8:0] held = 9'd0;
   logic       prev_vld = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk_core);
      cyc++;
   end

   initial forever begin
      @(posedge clk_core);
      #1;
      case (rdy_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = ~m_axis_tready;
         default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // output monitor: sampled at negedge, where every DUT output is settled for the next edge
   initial forever begin
      @(negedge clk_core);
      if (clk_core_rst) begin
         held_vld = 1'b0;
         prev_vld = 1'b0;
      end else begin
         if (held_vld)
            chk("stall_hold", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({1'b1, held}));
         held_vld = m_axis_tvalid && !m_axis_tready;
         held     = {m_axis_tlast, m_axis_tdata};
         if (m_axis_tvalid && !prev_vld) rise_cyc = cyc;
         prev_vld = m_axis_tvalid;
         if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tlast, m_axis_tdata});
            if (!first_out_seen) begin
               first_out_cyc  = cyc;
               first_out_seen = 1'b1;
            end
            last_out_cyc = cyc;
         end
         if (!s_axis_tready) lowcnt++;
         if (s_axis_tready && m_axis_tvalid) overlap++;
         if (stat_frame_dropped) pulses++;
      end
   end

   // reference model: a frame of 1..DEPTH bytes becomes [dest][len][bytes], longer frames vanish
   task automatic model_frame(input logic [7:0] dest, input logic [7:0] fr[$]);
      if (fr.size() <= DEPTH) begin
         exp_q.push_back({1'b0, dest});
         exp_q.push_back({1'b0, 8'(fr.size())});
         foreach (fr[i]) exp_q.push_back({(i == fr.size() - 1), fr[i]});
      end else begin
         exp_drops = (exp_drops >= 16'hFFFF) ? 16'hFFFF : exp_drops + 1;
      end
   endtask

   // called at a negedge; returns at the negedge right after the accepting edge
   task automatic drive_byte(input logic [7:0] d, input logic [7:0] dest, input logic last);
      int n = 0;
      logic hs = 1'b0;
      s_axis_tdata  = d;
      s_axis_tdest  = dest;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      while (!hs) begin
         #1;
         hs = s_axis_tready;
         @(negedge clk_core);
         n++;
         if (!hs && n > 400) begin
            checks++;
            errors++;
            $error("FAIL s_hs_timeout observed=no_handshake expected=handshake");
            break;
         end
      end
      hs_cyc        = cyc;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] dest, input logic [7:0] fr[$], input bit gaps);
      model_frame(dest, fr);
      foreach (fr[i]) begin
         if (gaps && $urandom_range(0, 2) == 0) @(negedge clk_core);
         drive_byte(fr[i], (i == 0) ? dest : 8'($urandom), (i == fr.size() - 1));
         if (i == 0) first_hs_cyc = hs_cyc;
      end
   endtask

   task automatic check_out(input string tag);
      int n = 0;
      while (got_q.size() < exp_q.size() && n < 3000) begin
         @(negedge clk_core);
         n++;
      end
      repeat (4) @(negedge clk_core);
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset(input string tag);
      s_axis_tvalid = 1'b0;
      #2;
      clk_core_rst = 1'b1;
      #1;
      chk({tag, "_s_rdy"}, s_axis_tready, 0);
      chk({tag, "_m_vld"}, m_axis_tvalid, 0);
      chk({tag, "_m_last"}, m_axis_tlast, 0);
      chk({tag, "_m_dat"}, m_axis_tdata, 0);
      chk({tag, "_drop"}, stat_frame_dropped, 0);
      chk({tag, "_cnt"}, stat_dropped_count, 0);
      chk({tag, "_busy"}, status_busy, 0);
      @(negedge clk_core);
      @(negedge clk_core);
      clk_core_rst = 1'b0;
      #1;
      chk({tag, "_rdy_pre_edge"}, s_axis_tready, 0);
      @(negedge clk_core);
      chk({tag, "_rdy_post_edge"}, s_axis_tready, 1);
      exp_drops = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fr[$];
      int len;

      do_reset("rst0");

      // frame 03 / AA BB CC with an always-ready sink
      fr = '{8'hAA, 8'hBB, 8'hCC};
      send_frame(8'd3, fr, 1'b0);
      check_out("s1");
      chk("s1_vld_rise", rise_cyc, hs_cyc);

      // single-byte frame: input side blocked for exactly the 3 output cycles
      lowcnt = 0;
      fr = '{8'h5E};
      send_frame(8'd7, fr, 1'b0);
      check_out("s2");
      chk("s2_rdy_low", lowcnt, 3);

      // exactly DEPTH bytes, back to back in both directions
      fr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      first_out_seen = 1'b0;
      send_frame(8'd1, fr, 1'b0);
      chk("s3_in_rate", hs_cyc - first_hs_cyc, 7);
      check_out("s3");
      chk("s3_out_rate", last_out_cyc - first_out_cyc, 9);

      // DEPTH+1 bytes: dropped, then a normal frame
      pulses = 0;
      fr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
      send_frame(8'd2, fr, 1'b0);
      check_out("s3_drop");
      chk("s3_pulses", pulses, 1);
      chk("s3_cnt", stat_dropped_count, exp_drops);
      fr = '{8'h11, 8'h22};
      send_frame(8'd2, fr, 1'b0);
      check_out("s3_after");

      // sink toggling every cycle
      rdy_mode = 1;
      overlap  = 0;
      fr = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      send_frame(8'd9, fr, 1'b0);
      check_out("s4");
      chk("s4_rdy_overlap", overlap, 0);
      rdy_mode = 0;
      @(negedge clk_core);

      // reset in the middle of a 5-byte frame
      drive_byte(8'hE0, 8'd5, 1'b0);
      drive_byte(8'hE1, 8'd5, 1'b0);
      do_reset("s5");
      fr = '{8'h66, 8'h77};
      send_frame(8'd4, fr, 1'b0);
      check_out("s5");

      // saturation of the drop counter
      force dut.drop_cnt = 16'hFFFF;
      @(negedge clk_core);
      release dut.drop_cnt;
      @(negedge clk_core);
      exp_drops = 16'hFFFF;
      chk("s6_cnt_pre", stat_dropped_count, 16'hFFFF);
      pulses = 0;
      fr = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8, 8'h9};
      send_frame(8'd6, fr, 1'b0);
      check_out("s6");
      chk("s6_pulses", pulses, 1);
      chk("s6_cnt", stat_dropped_count, exp_drops);

      // randomized frames, random gaps and random sink stalls
      do_reset("r_rst");
      pulses   = 0;
      rdy_mode = 2;
      for (int k = 0; k < 24; k++) begin
         len = (k == 0) ? 11 : (k == 1) ? DEPTH : $urandom_range(1, 11);
         fr.delete();
         for (int j = 0; j < len; j++) fr.push_back(8'($urandom));
         send_frame(8'($urandom), fr, 1'b1);
      end
      check_out("rand");
      chk("rand_pulses", pulses, exp_drops);
      chk("rand_cnt", stat_dropped_count, exp_drops);
      chk("rand_overlap", overlap, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
